// File: rtl/bram_lsu.sv
// bram_lsu: load/store unit between a core request port and a single-port BRAM.
// Ports: clk, rst; req_* (core request), resp_* (core response), mem_* (BRAM).
module bram_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [11:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [31:0] mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_WR
    } state_t;

    state_t      state, state_nx;
    logic [11:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [15:0] lat_wdata;

    logic        accept;
    logic        err;
    logic        word_st;
    logic [31:0] rd_sh;
    logic [31:0] ld_data;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Ready drops combinationally with rst so nothing is accepted in reset.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign err = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign word_st = req_we && (req_size == 2'b10);

    // Halfwords are aligned, so a byte-lane shift also selects the half.
    assign rd_sh = mem_rd_data >> {lat_addr[1:0], 3'b000};

    always_comb begin
        ld_data = mem_rd_data;
        case (lat_size)
            2'b00: ld_data = {{24{lat_signed & rd_sh[7]}}, rd_sh[7:0]};
            2'b01: ld_data = {{16{lat_signed & rd_sh[15]}}, rd_sh[15:0]};
            default: ld_data = mem_rd_data;
        endcase
    end

    always_comb begin
        lane_mask = 32'h0;
        lane_data = 32'h0;
        case (lat_size)
            2'b00: begin
                lane_mask = 32'h0000_00FF << {lat_addr[1:0], 3'b000};
                lane_data = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF << {lat_addr[1], 4'b0000};
                lane_data = {2{lat_wdata}};
            end
            default: begin
                lane_mask = 32'h0;
                lane_data = 32'h0;
            end
        endcase
        merged = (mem_rd_data & ~lane_mask) | (lane_data & lane_mask);
    end

    always_comb begin
        state_nx    = state;
        mem_addr    = lat_addr[11:2];
        mem_wr_data = 32'h0;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        case (state)
            IDLE: begin
                mem_addr = req_addr[11:2];
                if (accept && !err) begin
                    if (word_st) begin
                        mem_wen     = 1'b1;
                        mem_wr_data = req_wdata;
                    end else begin
                        mem_ren  = 1'b1;
                        state_nx = req_we ? RMW_WR : RD_WAIT;
                    end
                end
            end
            RD_WAIT: state_nx = IDLE;
            RMW_WR: begin
                mem_wen     = 1'b1;
                mem_wr_data = merged;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
            lat_addr   <= 12'h0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_wdata  <= 16'h0;
        end else begin
            state      <= state_nx;
            resp_valid <= 1'b0;
            if (accept) begin
                lat_addr   <= req_addr;
                lat_size   <= req_size;
                lat_signed <= req_signed;
                lat_wdata  <= req_wdata[15:0];
                if (err || word_st) begin
                    resp_valid <= 1'b1;
                    resp_err   <= err;
                    resp_data  <= 32'h0;
                end
            end
            if (state == RD_WAIT) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_data  <= ld_data;
            end
            if (state == RMW_WR) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_data  <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_bram_lsu.sv
// tb_bram_lsu: directed bench for bram_lsu with a behavioural BRAM model.
// Inputs change on the falling edge; checks are taken 1 ns later.
module tb_bram_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rd_data;

    logic [31:0] mem [1024];

    int vectors = 0;
    int errors  = 0;
    int pulses  = 0;

    bram_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wen     (mem_wen),
        .mem_ren     (mem_ren),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wr_data;
        if (mem_ren) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [11:0] a,
                       input logic [1:0] s, input logic sg,
                       input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_size   = s;
        req_signed = sg;
        req_wdata  = wd;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 12'h0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_wdata  = 32'h0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wstore(input logic [11:0] a, input logic [31:0] d);
        nxt(); req(1'b1, a, 2'b10, 1'b0, d);
        nxt(); idle();
    endtask

    // Load with 2-cycle latency; checks the result in the resp_valid cycle.
    task automatic load(input string tag, input logic [11:0] a,
                        input logic [1:0] s, input logic sg,
                        input logic [31:0] exp);
        nxt(); req(1'b0, a, s, sg, 32'h0); #1;
        check({tag, "_ren"}, {31'b0, mem_ren}, 32'd1);
        nxt(); idle(); #1;
        check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
        nxt(); #1;
        check({tag, "_vld"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_data"}, resp_data, exp);
    endtask

    initial begin
        mem_rd_data = 32'h0;
        rst = 1'b1;
        idle();
        // A request during reset must not reach memory.
        nxt(); req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0); #1;
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_ren", {31'b0, mem_ren}, 32'd0);
        check("rst_wen", {31'b0, mem_wen}, 32'd0);
        check("rst_rvld", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_data, 32'h0);
        check("rst_rerr", {31'b0, resp_err}, 32'd0);
        nxt(); idle(); rst = 1'b0; #1;
        check("rel_ready", {31'b0, req_ready}, 32'd1);

        // Word store then word load.
        nxt(); req(1'b1, 12'h010, 2'b10, 1'b0, 32'hDEAD_BEEF); #1;
        check("ws_wen", {31'b0, mem_wen}, 32'd1);
        check("ws_ren", {31'b0, mem_ren}, 32'd0);
        check("ws_addr", {22'b0, mem_addr}, 32'd4);
        check("ws_wdat", mem_wr_data, 32'hDEAD_BEEF);
        nxt(); idle(); #1;
        check("ws_vld", {31'b0, resp_valid}, 32'd1);
        check("ws_err", {31'b0, resp_err}, 32'd0);
        check("ws_mem", mem[4], 32'hDEAD_BEEF);
        load("lw", 12'h010, 2'b10, 1'b0, 32'hDEAD_BEEF);
        nxt(); #1;
        check("lw_pulse", {31'b0, resp_valid}, 32'd0);
        check("lw_hold", resp_data, 32'hDEAD_BEEF);

        // Sub-word loads.
        wstore(12'h020, 32'h80FF_7F01);
        wstore(12'h030, 32'h1122_3344);
        wstore(12'h040, 32'hCAFE_F00D);
        load("lbs3", 12'h023, 2'b00, 1'b1, 32'hFFFF_FF80);
        load("lbu1", 12'h021, 2'b00, 1'b0, 32'h0000_007F);
        load("lbs0", 12'h020, 2'b00, 1'b1, 32'h0000_0001);
        load("lhs2", 12'h022, 2'b01, 1'b1, 32'hFFFF_80FF);
        load("lhu2", 12'h022, 2'b01, 1'b0, 32'h0000_80FF);

        // Halfword read-modify-write.
        nxt(); req(1'b1, 12'h032, 2'b01, 1'b0, 32'h0000_ABCD); #1;
        check("sh_ren", {31'b0, mem_ren}, 32'd1);
        check("sh_wen0", {31'b0, mem_wen}, 32'd0);
        nxt(); idle(); #1;
        check("sh_ready", {31'b0, req_ready}, 32'd0);
        check("sh_wen1", {31'b0, mem_wen}, 32'd1);
        check("sh_ren1", {31'b0, mem_ren}, 32'd0);
        check("sh_addr", {22'b0, mem_addr}, 32'd12);
        check("sh_wdat", mem_wr_data, 32'hABCD_3344);
        check("sh_vld1", {31'b0, resp_valid}, 32'd0);
        nxt(); #1;
        check("sh_vld2", {31'b0, resp_valid}, 32'd1);
        check("sh_err", {31'b0, resp_err}, 32'd0);
        check("sh_mem", mem[12], 32'hABCD_3344);

        // Byte RMW: only wdata[7:0] lands in lane 1.
        nxt(); req(1'b1, 12'h031, 2'b00, 1'b0, 32'hFFFF_FF55);
        nxt(); idle(); #1;
        check("sb_wdat", mem_wr_data, 32'hABCD_5544);
        nxt(); #1;
        check("sb_vld", {31'b0, resp_valid}, 32'd1);
        check("sb_mem", mem[12], 32'hABCD_5544);

        // Misaligned word load, then illegal size back to back.
        nxt(); req(1'b0, 12'h006, 2'b10, 1'b0, 32'h0); #1;
        check("mis_ren", {31'b0, mem_ren}, 32'd0);
        check("mis_wen", {31'b0, mem_wen}, 32'd0);
        nxt(); req(1'b0, 12'h000, 2'b11, 1'b0, 32'h0); #1;
        check("mis_vld", {31'b0, resp_valid}, 32'd1);
        check("mis_err", {31'b0, resp_err}, 32'd1);
        check("mis_data", resp_data, 32'h0);
        check("ill_ren", {31'b0, mem_ren}, 32'd0);
        check("ill_wen", {31'b0, mem_wen}, 32'd0);
        nxt(); idle(); #1;
        check("ill_vld", {31'b0, resp_valid}, 32'd1);
        check("ill_err", {31'b0, resp_err}, 32'd1);
        check("ill_data", resp_data, 32'h0);
        nxt(); req(1'b1, 12'h011, 2'b01, 1'b0, 32'h0); #1;
        check("mish_wen", {31'b0, mem_wen}, 32'd0);
        check("mish_ren", {31'b0, mem_ren}, 32'd0);
        nxt(); idle(); #1;
        check("mish_err", {31'b0, resp_err}, 32'd1);

        // Reset pulsed while in RMW_WR aborts the store.
        nxt(); req(1'b1, 12'h040, 2'b00, 1'b0, 32'h0000_0012); #1;
        check("ra_ren", {31'b0, mem_ren}, 32'd1);
        nxt(); idle(); rst = 1'b1; #1;
        check("ra_wen", {31'b0, mem_wen}, 32'd0);
        check("ra_vld", {31'b0, resp_valid}, 32'd0);
        check("ra_ready", {31'b0, req_ready}, 32'd0);
        nxt(); rst = 1'b0; #1;
        check("ra_rel", {31'b0, req_ready}, 32'd1);
        check("ra_vld2", {31'b0, resp_valid}, 32'd0);
        check("ra_wen2", {31'b0, mem_wen}, 32'd0);
        check("ra_mem", mem[16], 32'hCAFE_F00D);
        nxt(); #1;
        check("ra_vld3", {31'b0, resp_valid}, 32'd0);

        // Three word stores with req_valid held high.
        nxt(); req(1'b1, 12'h100, 2'b10, 1'b0, 32'hAAAA_0001); #1;
        check("tp_rdy1", {31'b0, req_ready}, 32'd1);
        check("tp_addr1", {22'b0, mem_addr}, 32'h40);
        nxt(); req(1'b1, 12'h104, 2'b10, 1'b0, 32'hAAAA_0002); #1;
        if (resp_valid) pulses++;
        check("tp_rdy2", {31'b0, req_ready}, 32'd1);
        check("tp_addr2", {22'b0, mem_addr}, 32'h41);
        nxt(); req(1'b1, 12'h108, 2'b10, 1'b0, 32'hAAAA_0003); #1;
        if (resp_valid) pulses++;
        check("tp_wen3", {31'b0, mem_wen}, 32'd1);
        check("tp_addr3", {22'b0, mem_addr}, 32'h42);
        nxt(); idle(); #1;
        if (resp_valid) pulses++;
        nxt(); #1;
        check("tp_end", {31'b0, resp_valid}, 32'd0);
        check("tp_pulses", pulses, 32'd3);
        check("tp_mem0", mem[64], 32'hAAAA_0001);
        check("tp_mem2", mem[66], 32'hAAAA_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
